// File: rtl/klp32_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : klp32_mem_pkg                                                  |
// | Purpose   : Shared types and constants for the KLP32V2 memory stage and    |
// |             the data-memory responder: load/store mode encoding (RISC-V    |
// |             funct3), responder FSM states, lane geometry, mode legality.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package klp32_mem_pkg;

  localparam int unsigned DMEM_DATA_W     = 32;
  localparam int unsigned DMEM_LANE_W     = 8;
  localparam int unsigned DMEM_LANES      = DMEM_DATA_W / DMEM_LANE_W;
  localparam int unsigned DMEM_WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Loads accept all five encodings; stores have no unsigned variants.
  function automatic logic ls_mode_legal(input logic [2:0] mode, input logic we);
    logic ok;
    ok = 1'b0;
    case (mode)
      LS_B, LS_H, LS_W: ok = 1'b1;
      LS_BU, LS_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : dmem_lane_align                                                |
// | Purpose   : Combinational byte-lane steering for the data-memory responder.|
// |             Produces store byte enables and lane-replicated store data,    |
// |             extracts and extends load data, and flags misalignment.        |
// | Revision  : 1.0  initial release                                           |
// | Macro     : DMEM_MISALIGN_TRAP_EN - when defined, misalign_o reports H/HU  |
// |             with addr[0]=1 and W with addr[1:0]!=0; otherwise tied low     |
// |             and the low address bits are ignored for H and W.              |
// | Ports     : mode_i     in  3   load/store mode (funct3)                    |
// |             addr_lo_i  in  2   byte address bits [1:0]                     |
// |             wdata_i    in  32  store data, LSB-justified                   |
// |             rword_i    in  32  RAM word read for a load                    |
// |             be_o       out 4   store byte enables                          |
// |             wdata_o    out 32  store data replicated across lanes          |
// |             rdata_o    out 32  extracted, extended load data               |
// |             misalign_o out 1   misaligned access                           |
// +----------------------------------------------------------------------------+
module dmem_lane_align
  import klp32_mem_pkg::*;
(
  input  logic [2:0]             mode_i,
  input  logic [1:0]             addr_lo_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  input  logic [DMEM_DATA_W-1:0] rword_i,
  output logic [DMEM_LANES-1:0]  be_o,
  output logic [DMEM_DATA_W-1:0] wdata_o,
  output logic [DMEM_DATA_W-1:0] rdata_o,
  output logic                   misalign_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  // Halfword lane pair chosen by addr[1] only; addr[0] never moves the pair.
  assign w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    case (mode_i)
      LS_B, LS_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (mode_i == LS_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      LS_H, LS_HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (mode_i == LS_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      LS_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    misalign_o = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (mode_i)
      LS_H, LS_HU: misalign_o = addr_lo_i[0];
      LS_W:        misalign_o = |addr_lo_i;
      default:     misalign_o = 1'b0;
    endcase
`else
    misalign_o = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : dmem_responder                                                 |
// | Purpose   : Data-memory responder for the KLP32V2 memory stage. Accepts    |
// |             one load/store at a time on a valid/ready request channel,     |
// |             waits WAIT_CYCLES, commits/reads a word-organised RAM and      |
// |             returns data/error on a valid/ready response channel.          |
// | Revision  : 1.0  initial release                                           |
// | Macro     : DMEM_MISALIGN_TRAP_EN - misaligned H/HU/W raise rsp_err and    |
// |             suppress the store (handled in dmem_lane_align).               |
// | Ports     : clk        in  1   clock                                       |
// |             reset      in  1   asynchronous active-high reset              |
// |             req_valid  in  1   request present                             |
// |             req_ready  out 1   responder can accept (IDLE only)            |
// |             req_we     in  1   1 = store, 0 = load                         |
// |             req_addr   in  32  byte address                                |
// |             req_wdata  in  32  store data, LSB-justified                   |
// |             req_mode   in  3   funct3 load/store mode                      |
// |             rsp_valid  out 1   response present                            |
// |             rsp_ready  in  1   consumer takes response                     |
// |             rsp_rdata  out 32  extended load data; 0 for stores/errors     |
// |             rsp_err    out 1   range, mode or misalignment error           |
// +----------------------------------------------------------------------------+
module dmem_responder
  import klp32_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  // The counter holds the remaining WAIT cycles minus one, so that WAIT
  // lasts exactly WAIT_CYCLES cycles and the response lands at T+1+WAIT_CYCLES.
  localparam logic [DMEM_WAIT_CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? '0 : DMEM_WAIT_CNT_W'(WAIT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [DMEM_WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  mode_q, mode_d;
  logic        we_q, we_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        w_accept;
  logic        w_commit;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_mode;
  logic        w_we;
  logic [29:0] w_word_off;
  logic        w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [31:0] w_rword;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;
  logic        w_misalign;
  logic        w_err;
  logic        w_wr_en;

  assign w_accept = req_valid & req_ready_q;

  // With WAIT_CYCLES=0 the commit happens on the accept edge itself, before
  // the request latch holds anything, so the live request is used in IDLE.
  assign w_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign w_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign w_mode  = (state_q == IDLE) ? req_mode  : mode_q;
  assign w_we    = (state_q == IDLE) ? req_we    : we_q;

  assign w_word_off = w_addr[31:2] - BASE_WORD;
  assign w_in_range = (w_addr[31:2] >= BASE_WORD) && (w_word_off < 30'(DEPTH_WORDS));
  assign w_idx      = w_word_off[IDX_W-1:0];
  assign w_rword    = w_in_range ? mem_q[w_idx] : '0;

  dmem_lane_align u_align (
    .mode_i     (w_mode),
    .addr_lo_i  (w_addr[1:0]),
    .wdata_i    (w_wdata),
    .rword_i    (w_rword),
    .be_o       (w_be),
    .wdata_o    (w_wdata_rep),
    .rdata_o    (w_rdata_ext),
    .misalign_o (w_misalign)
  );

  assign w_err   = ~w_in_range | ~ls_mode_legal(w_mode, w_we) | w_misalign;
  assign w_wr_en = w_commit & w_we & ~w_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mode_d      = mode_q;
    we_d        = we_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    w_commit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          mode_d  = req_mode;
          we_d    = req_we;
          if (WAIT_CYCLES == 0) begin
            w_commit = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          w_commit = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_commit) begin
      rsp_valid_d = 1'b1;
      err_d       = w_err;
      rdata_d     = (w_err | w_we) ? '0 : w_rdata_ext;
    end

    req_ready_d = (state_d == IDLE);
  end

  // RAM is never cleared; the reset gate keeps a pending commit from
  // landing on an edge where reset is held.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem_q[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_dmem_responder                                              |
// | Purpose   : Self-checking bench for dmem_responder: directed steps plus    |
// |             randomized loads/stores against a byte-addressed model.        |
// | Revision  : 1.0  initial release                                           |
// | Macro     : DMEM_MISALIGN_TRAP_EN selects the misalignment expectations.   |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int unsigned WAITC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_mode = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] m [0:4*DEPTH-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference: a request touches size bytes at the address
  // rounded down to its natural size; loads assemble little-endian.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] mode, output logic [31:0] rd, output logic er);
    int size;
    logic sx;
    longint off;
    logic [31:0] v, ones;
    size = 0; sx = 1'b0; er = 1'b0; rd = '0; ones = '1;
    case (mode)
      3'd0: begin size = 1; sx = 1'b1; end
      3'd1: begin size = 2; sx = 1'b1; end
      3'd2: begin size = 4; end
      3'd4: begin size = 1; er = we; end
      3'd5: begin size = 2; er = we; end
      default: er = 1'b1;
    endcase
    off = longint'(addr) - longint'(BASE);
    if (off < 0 || off >= 4 * longint'(DEPTH)) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (size > 1 && (off % size) != 0) er = 1'b1;
`endif
    if (!er) begin
      off = off - (off % size);
      if (we) begin
        for (int i = 0; i < size; i++) m[int'(off) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(m[int'(off) + i]) << (8*i));
        if (sx && size < 4 && v[8*size-1]) v = v | (ones << (8*size));
        rd = v;
      end
    end
  endtask

  // Entered and left on a falling edge.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] mode, input int hold,
                     input logic [31:0] exp_rd, input logic exp_er);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "/req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_mode = mode;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "/latency"}, 32'(n), 32'(1 + WAITC));
    for (int h = 0; h < hold; h++) begin
      check({tag, "/hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "/hold_rdy"}, {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    check({tag, "/rdata"}, rsp_rdata, exp_rd);
    check({tag, "/err"}, {31'b0, rsp_err}, {31'b0, exp_er});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "/rsp_done"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "/idle_rdy"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic mtxn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] mode, input int hold);
    logic [31:0] rd;
    logic er;
    model(we, addr, wd, mode, rd, er);
    txn(tag, we, addr, wd, mode, hold, rd, er);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  md;
    logic        we;
    int k;

    // Reset held three cycles.
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_ready_before_edge", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("rel_ready_after_edge", {31'b0, req_ready}, 32'd1);

    txn("sw_dead",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 1'b0);
    txn("lw_dead",  1'b0, 32'h10, 32'h0,        3'b010, 0, 32'hDEADBEEF, 1'b0);
    txn("sw_zero",  1'b1, 32'h10, 32'h0,        3'b010, 0, 32'h0, 1'b0);
    txn("sb_80",    1'b1, 32'h13, 32'h80,       3'b000, 0, 32'h0, 1'b0);
    txn("lb_80",    1'b0, 32'h13, 32'h0,        3'b000, 0, 32'hFFFFFF80, 1'b0);
    txn("lbu_80",   1'b0, 32'h13, 32'h0,        3'b100, 0, 32'h00000080, 1'b0);
    txn("lw_80",    1'b0, 32'h10, 32'h0,        3'b010, 0, 32'h80000000, 1'b0);
    txn("lw_bp5",   1'b0, 32'h10, 32'h0,        3'b010, 5, 32'h80000000, 1'b0);

    // Out-of-range store must not alias into word 0.
    txn("sw_w0",    1'b1, 32'h0, 32'h12345678,  3'b010, 0, 32'h0, 1'b0);
    txn("lw_oor",   1'b0, BASE + 4*DEPTH, 32'h0, 3'b010, 0, 32'h0, 1'b1);
    txn("sw_oor",   1'b1, BASE + 4*DEPTH, 32'hFFFFFFFF, 3'b010, 0, 32'h0, 1'b1);
    txn("lw_w0",    1'b0, 32'h0, 32'h0,         3'b010, 0, 32'h12345678, 1'b0);
    txn("ld_m011",  1'b0, 32'h0, 32'h0,         3'b011, 0, 32'h0, 1'b1);
    txn("st_m100",  1'b1, 32'h0, 32'hAAAAAAAA,  3'b100, 0, 32'h0, 1'b1);
    txn("lw_w0b",   1'b0, 32'h0, 32'h0,         3'b010, 0, 32'h12345678, 1'b0);
    txn("sh_hi",    1'b1, 32'h2, 32'h0000BEEF,  3'b001, 0, 32'h0, 1'b0);
    txn("lw_sh",    1'b0, 32'h0, 32'h0,         3'b010, 0, 32'hBEEF5678, 1'b0);

    txn("sw_a1",    1'b1, 32'h10, 32'hA1B2C3D4, 3'b010, 0, 32'h0, 1'b0);
    txn("lhu_12",   1'b0, 32'h12, 32'h0,        3'b101, 0, 32'h0000A1B2, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    txn("lh_11",    1'b0, 32'h11, 32'h0,        3'b001, 0, 32'h0, 1'b1);
    txn("lw_13",    1'b0, 32'h13, 32'h0,        3'b010, 0, 32'h0, 1'b1);
`else
    txn("lh_11",    1'b0, 32'h11, 32'h0,        3'b001, 0, 32'hFFFFC3D4, 1'b0);
    txn("lw_13",    1'b0, 32'h13, 32'h0,        3'b010, 0, 32'hA1B2C3D4, 1'b0);
`endif

    // Reset during WAIT drops the pending store and issues no response.
    txn("sw_20",    1'b1, 32'h20, 32'h11111111, 3'b010, 0, 32'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA55AA; req_mode = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid_after", {31'b0, rsp_valid}, 32'd0);
    txn("lw_20",    1'b0, 32'h20, 32'h0,        3'b010, 0, 32'h11111111, 1'b0);

    // Randomized traffic over a model-initialised region.
    for (int w = 0; w < 32; w++) mtxn("rnd_fill", 1'b1, 32'(4*w), $urandom, 3'b010, 0);
    for (int t = 0; t < 200; t++) begin
      k  = $urandom_range(0, 9);
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 127));
      wd = $urandom;
      if (k < 8) begin
        if (we) md = 3'($urandom_range(0, 2));
        else begin
          md = 3'($urandom_range(0, 4));
          if (md == 3'd3) md = 3'd5;
        end
      end else if (k == 8) begin
        md = we ? 3'($urandom_range(3, 7)) : 3'd3 + 3'(3 * $urandom_range(0, 1));
        if (!we && md == 3'd6) md = 3'($urandom_range(6, 7));
      end else begin
        md = 3'd2;
        a  = BASE + 4*DEPTH + 32'($urandom_range(0, 65535));
      end
      mtxn("rnd", we, a, wd, md, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
